// File: rtl/inst_loader.sv
// inst_loader: assembles a LE byte stream into imem words, then starts the core.
// Define INST_LOADER_CHECKSUM_EN to require and verify a trailing sum byte.
module inst_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  load_done,
  output logic                  core_start,
  output logic                  err_size,
  output logic                  err_checksum
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [32:0]         CAP = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = 1;

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [23:0]         part;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [ADDR_WIDTH:0] n_words;
  logic                xfer;
  logic                last;
  logic [31:0]         word;

  assign rx_ready = (state != S_DONE);
  assign xfer     = rx_valid & rx_ready;
  assign last     = xfer && (byte_cnt == 2'd3);
  // Earlier bytes shift down, so the 4th byte lands on top.
  assign word     = {rx_data, part};

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       csum_err;
  assign err_checksum = csum_err;
`else
  assign err_checksum = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_HDR;
      byte_cnt   <= 2'd0;
      part       <= 24'd0;
      word_cnt   <= '0;
      n_words    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      load_done  <= 1'b0;
      core_start <= 1'b0;
      err_size   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum        <= 8'd0;
      csum_err   <= 1'b0;
`endif
    end else begin
      imem_we    <= 1'b0;
      core_start <= 1'b0;
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        part     <= {rx_data, part[23:8]};
      end
      unique case (state)
        S_HDR: begin
          if (last) begin
            n_words <= word[ADDR_WIDTH:0];
            if ({1'b0, word} > CAP) begin
              state    <= S_ERR;
              err_size <= 1'b1;
            end else if (word == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state      <= S_CSUM;
`else
              state      <= S_DONE;
              load_done  <= 1'b1;
              core_start <= 1'b1;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
`ifdef INST_LOADER_CHECKSUM_EN
          if (xfer) sum <= sum + rx_data;
`endif
          if (last) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
            imem_wdata <= word;
            if (word_cnt == n_words - ONE) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state      <= S_CSUM;
`else
              state      <= S_DONE;
              load_done  <= 1'b1;
              core_start <= 1'b1;
`endif
            end else begin
              word_cnt <= word_cnt + ONE;
            end
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            if (rx_data == sum) begin
              state      <= S_DONE;
              load_done  <= 1'b1;
              core_start <= 1'b1;
            end else begin
              state    <= S_ERR;
              csum_err <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
